traffic_request_latch: RTL and testbench

//   Front-end for the 4-way controller's request input (ui_in[3:0]): conditions four raw push-button/loop-detector lines.

---
 rtl/traffic_request_latch_if.sv | 21 ++
 rtl/traffic_request_latch.sv | 107 ++++++++++
 tb/tb_traffic_request_latch.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/traffic_request_latch_if.sv
// rtl/traffic_request_latch_if.sv - request/serve signal bundle between controller and request latch
interface traffic_request_latch_if;
    logic [3:0] btn_in;
    logic       tick;
    logic       serve_ack;
    logic [1:0] serve_dir;
    logic [3:0] req_out;
    logic       req_any;
    logic [1:0] next_dir;
    logic       next_vld;

    modport master (
        output btn_in, tick, serve_ack, serve_dir,
        input  req_out, req_any, next_dir, next_vld
    );

    modport slave (
        input  btn_in, tick, serve_ack, serve_dir,
        output req_out, req_any, next_dir, next_vld
    );
endinterface

// File: rtl/traffic_request_latch.sv
// rtl/traffic_request_latch.sv - sync, debounce and sticky-latch four direction requests
// Optional round-robin next-direction search enabled by defining REQ_NEXT_DIR_EN.
module traffic_request_latch #(
    parameter int DEB_COUNT = 4,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    traffic_request_latch_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       s1_q, s2_q;
    logic [3:0]       deb_q, deb_d, deb_prev_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       req_q, req_d;
    logic             req_any_q;
    logic [3:0]       rise, clr;

    always_comb begin
        deb_d = deb_q;
        for (int n = 0; n < 4; n++) begin
            cnt_d[n] = cnt_q[n];
            if (s2_q[n] == deb_q[n]) begin
                cnt_d[n] = '0;
            end else if (bus.tick) begin
                if (cnt_q[n] == CNT_LAST) begin
                    deb_d[n] = s2_q[n];
                    cnt_d[n] = '0;
                end else begin
                    cnt_d[n] = cnt_q[n] + CNT_ONE;
                end
            end
        end
    end

    // Set is applied after clear so a press landing on its own service is kept.
    always_comb begin
        rise  = deb_q & ~deb_prev_q;
        clr   = bus.serve_ack ? (4'b0001 << bus.serve_dir) : 4'b0000;
        req_d = (req_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            req_q      <= '0;
            req_any_q  <= 1'b0;
            for (int n = 0; n < 4; n++) cnt_q[n] <= '0;
        end else begin
            s1_q       <= bus.btn_in;
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            req_q      <= req_d;
            req_any_q  <= |req_d;
            for (int n = 0; n < 4; n++) cnt_q[n] <= cnt_d[n];
        end
    end

    assign bus.req_out = req_q;
    assign bus.req_any = req_any_q;

`ifdef REQ_NEXT_DIR_EN
    logic [1:0] last_dir_q, base, idx;
    logic [1:0] next_dir_q, next_dir_d;
    logic       next_vld_q, next_vld_d;

    // Walk from farthest to nearest so the nearest requester after base wins.
    always_comb begin
        base       = bus.serve_ack ? bus.serve_dir : last_dir_q;
        next_dir_d = base;
        next_vld_d = 1'b0;
        idx        = base;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (req_d[idx]) begin
                next_dir_d = idx;
                next_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dir_q <= '0;
            next_dir_q <= '0;
            next_vld_q <= 1'b0;
        end else begin
            if (bus.serve_ack) last_dir_q <= bus.serve_dir;
            next_dir_q <= next_dir_d;
            next_vld_q <= next_vld_d;
        end
    end

    assign bus.next_dir = next_dir_q;
    assign bus.next_vld = next_vld_q;
`else
    assign bus.next_dir = 2'b00;
    assign bus.next_vld = 1'b0;
`endif
endmodule

// File: tb/tb_traffic_request_latch.sv
// tb/tb_traffic_request_latch.sv - directed self-checking bench for traffic_request_latch
module tb_traffic_request_latch;
`ifdef REQ_NEXT_DIR_EN
    localparam bit NDE = 1'b1;
`else
    localparam bit NDE = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    traffic_request_latch_if bus ();

    traffic_request_latch #(.DEB_COUNT(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic serve(input logic [1:0] dir);
        bus.serve_ack = 1'b1;
        bus.serve_dir = dir;
        cyc(1);
        bus.serve_ack = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.btn_in    = 4'hF;
        bus.tick      = 1'b1;
        bus.serve_ack = 1'b0;
        bus.serve_dir = 2'd0;

        // reset with all buttons held
        cyc(3);
        chk("rst_req_out", 8'(bus.req_out), 8'h0);
        chk("rst_req_any", 8'(bus.req_any), 8'h0);
        chk("rst_next_vld", 8'(bus.next_vld), 8'h0);
        chk("rst_next_dir", 8'(bus.next_dir), 8'h0);
        rst_n = 1'b1;
        cyc(6);
        chk("latency_c6", 8'(bus.req_out), 8'h0);
        cyc(1);
        chk("latency_c7", 8'(bus.req_out), 8'hF);
        chk("latency_any", 8'(bus.req_any), 8'h1);

        // release is ignored; serve each direction
        bus.btn_in = 4'h0;
        serve(2'd0);
        chk("serve0", 8'(bus.req_out), 8'hE);
        chk("serve0_next_dir", 8'(bus.next_dir), NDE ? 8'h1 : 8'h0);
        serve(2'd1);
        chk("serve1", 8'(bus.req_out), 8'hC);
        serve(2'd2);
        chk("serve2", 8'(bus.req_out), 8'h8);
        serve(2'd3);
        chk("serve3", 8'(bus.req_out), 8'h0);
        chk("serve3_any", 8'(bus.req_any), 8'h0);
        cyc(10);
        chk("release_no_set", 8'(bus.req_out), 8'h0);

        // glitch of 3 cycles rejected, 4-cycle press accepted
        bus.btn_in = 4'h4;
        cyc(3);
        bus.btn_in = 4'h0;
        cyc(10);
        chk("glitch", 8'(bus.req_out), 8'h0);
        bus.btn_in = 4'h4;
        cyc(6);
        chk("press_c6", 8'(bus.req_out), 8'h0);
        cyc(1);
        chk("press_c7", 8'(bus.req_out), 8'h4);

        // add bit 0 while bit 2 stays held, then serve both
        bus.btn_in = 4'h5;
        cyc(7);
        chk("req_5", 8'(bus.req_out), 8'h5);
        serve(2'd0);
        chk("serve_0_of_5", 8'(bus.req_out), 8'h4);
        serve(2'd2);
        chk("serve_2_of_4", 8'(bus.req_out), 8'h0);
        chk("serve_2_any", 8'(bus.req_any), 8'h0);
        cyc(10);
        chk("held_no_rearm", 8'(bus.req_out), 8'h0);
        serve(2'd3);
        chk("clear_zero_bit", 8'(bus.req_out), 8'h0);
        bus.btn_in = 4'h0;
        cyc(10);

        // set and clear of bit 1 in the same cycle
        bus.btn_in = 4'h2;
        cyc(6);
        serve(2'd1);
        chk("collision_set_wins", 8'(bus.req_out), 8'h2);
        serve(2'd1);
        chk("collision_then_clear", 8'(bus.req_out), 8'h0);
        bus.btn_in = 4'h0;
        cyc(10);

        // tick every 10 cycles; counter holds between ticks
        bus.tick   = 1'b0;
        bus.btn_in = 4'h8;
        cyc(3);
        for (int t = 0; t < 3; t++) begin
            bus.tick = 1'b1;
            cyc(1);
            bus.tick = 1'b0;
            cyc(9);
        end
        chk("tick_after_3", 8'(bus.req_out), 8'h0);
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
        chk("tick_accept_edge", 8'(bus.req_out), 8'h0);
        cyc(1);
        chk("tick_after_4", 8'(bus.req_out), 8'h8);
        bus.tick   = 1'b1;
        bus.btn_in = 4'h0;
        serve(2'd3);
        chk("tick_served", 8'(bus.req_out), 8'h0);
        cyc(10);

        // round-robin next direction
        bus.btn_in = 4'h9;
        cyc(7);
        chk("rr_req_9", 8'(bus.req_out), 8'h9);
        bus.btn_in = 4'h0;
        serve(2'd0);
        chk("rr_req_8", 8'(bus.req_out), 8'h8);
        chk("rr_dir_3", 8'(bus.next_dir), NDE ? 8'h3 : 8'h0);
        chk("rr_vld_3", 8'(bus.next_vld), NDE ? 8'h1 : 8'h0);
        cyc(10);
        bus.btn_in = 4'h1;
        cyc(7);
        chk("rr_req_9b", 8'(bus.req_out), 8'h9);
        bus.btn_in = 4'h0;
        serve(2'd3);
        chk("rr_req_1", 8'(bus.req_out), 8'h1);
        chk("rr_dir_wrap", 8'(bus.next_dir), 8'h0);
        chk("rr_vld_wrap", 8'(bus.next_vld), NDE ? 8'h1 : 8'h0);
        serve(2'd0);
        chk("rr_req_0", 8'(bus.req_out), 8'h0);
        chk("rr_vld_none", 8'(bus.next_vld), 8'h0);
        chk("rr_dir_none", 8'(bus.next_dir), 8'h0);
        cyc(10);

        // reset with a pending request while button stays held
        bus.btn_in = 4'h2;
        cyc(7);
        chk("pre_reset_req", 8'(bus.req_out), 8'h2);
        rst_n = 1'b0;
        #1;
        chk("async_reset_req", 8'(bus.req_out), 8'h0);
        chk("async_reset_any", 8'(bus.req_any), 8'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        chk("rearm_c6", 8'(bus.req_out), 8'h0);
        cyc(1);
        chk("rearm_c7", 8'(bus.req_out), 8'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
